// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// State encoding and the default image base address live here.
package imem_loader_pkg;

  localparam int STATE_W = 3;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h20;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int ctr_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/loader_hold_timer.sv
// Loadable down-counter that times the processor-reset hold period.
// o_expire flags the final hold cycle so the FSM can leave HOLD.
module loader_hold_timer
  import imem_loader_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expire
);

  localparam int TW = ctr_w(HOLD_CYCLES);

  logic [TW-1:0] r_cnt;

  // load the full hold length, then count down while holding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= TW'(HOLD_CYCLES);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - TW'(1);
    end
  end

  assign o_expire = i_dec && (r_cnt == TW'(1));

endmodule

// File: rtl/imem_loader.sv
// Stream-to-instruction-memory program loader with CPU reset control.
// Optional running checksum check: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int              DATA_W      = 16,
  parameter int              ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
  parameter int              MAX_WORDS   = 1024,
  parameter int              HOLD_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load_start,
  input  logic                           s_valid,
  input  logic [DATA_W-1:0]              s_data,
  input  logic                           s_last,
`ifdef IMEM_LOADER_CHECKSUM_EN
  input  logic [DATA_W-1:0]              chk_expected,
  output logic [DATA_W-1:0]              checksum,
`endif
  output logic                           s_ready,
  output logic                           mem_we,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  output logic                           cpu_reset,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [$clog2(MAX_WORDS+1)-1:0] word_count
);

  localparam int            CW  = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] LIM = CW'(MAX_WORDS - 1);

  state_t r_state;
  state_t w_next;

  logic              w_acc;
  logic              w_start;
  logic              w_expire;
  logic              w_chk_bad;
  logic              w_hold_ld;
  logic              w_in_hold;
  logic              w_s_ready;
  logic              w_busy;
  logic              w_cpu_rst;
  logic              w_done;
  logic              w_err;
  logic              w_we;
  logic [CW-1:0]     w_cnt;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  assign w_acc     = s_valid & s_ready;
  assign w_start   = load_start
                   & (r_state != ST_LOAD)
                   & (r_state != ST_HOLD);
  assign w_hold_ld = w_acc & s_last;
  assign w_in_hold = (r_state == ST_HOLD);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic [DATA_W-1:0] w_sum;

  assign w_sum     = r_sum + s_data;
  assign w_chk_bad = (w_sum != chk_expected);
  assign checksum  = r_sum;

  // running sum of accepted words, restarted by each load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum <= '0;
    end else if (w_start) begin
      r_sum <= '0;
    end else if (w_acc) begin
      r_sum <= w_sum;
    end
  end
`else
  assign w_chk_bad = 1'b0;
`endif

  loader_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .clk     (clk),
    .rst_n   (reset),
    .i_load  (w_hold_ld),
    .i_dec   (w_in_hold),
    .o_expire(w_expire)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state decode; a word at the limit without s_last overflows
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (load_start) w_next = ST_LOAD;
      ST_LOAD: begin
        if (w_acc) begin
          if (s_last) begin
            w_next = w_chk_bad ? ST_ERR : ST_HOLD;
          end else if (word_count == LIM) begin
            w_next = ST_ERR;
          end
        end
      end
      ST_HOLD: if (w_expire) w_next = ST_RUN;
      ST_RUN:  if (load_start) w_next = ST_LOAD;
      ST_ERR:  if (load_start) w_next = ST_LOAD;
      default: w_next = ST_IDLE;
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    w_s_ready = (w_next == ST_LOAD);
    w_busy    = (w_next == ST_LOAD) || (w_next == ST_HOLD);
    w_cpu_rst = (w_next != ST_RUN);
    w_done    = (r_state == ST_HOLD) && (w_next == ST_RUN);
    w_we      = w_acc;
    w_addr    = mem_addr;
    w_wdata   = mem_wdata;
    w_cnt     = word_count;
    w_err     = error;
    unique case (1'b1)
      w_start: begin
        w_cnt = '0;
        w_err = 1'b0;
      end
      w_acc: begin
        w_cnt   = word_count + CW'(1);
        w_err   = error | (w_next == ST_ERR);
        w_addr  = BASE_ADDR + ADDR_W'(word_count);
        w_wdata = s_data;
      end
      default: begin
        w_cnt = word_count;
      end
    endcase
  end

  // output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_ready    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      s_ready    <= w_s_ready;
      mem_we     <= w_we;
      mem_addr   <= w_addr;
      mem_wdata  <= w_wdata;
      cpu_reset  <= w_cpu_rst;
      busy       <= w_busy;
      done       <= w_done;
      error      <= w_err;
      word_count <= w_cnt;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader against a queue-based model.
// Also exercises the checksum ports when IMEM_LOADER_CHECKSUM_EN is set.
module tb_imem_loader;

  localparam int DW   = 16;
  localparam int AW   = 32;
  localparam int MAXW = 6;
  localparam int HOLD = 2;
  localparam int CW   = $clog2(MAXW + 1);
  localparam logic [AW-1:0] BASE = 32'h20;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          s_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DW-1:0] chk_expected;
  logic [DW-1:0] checksum;
  logic [DW-1:0] exp_sum;
  bit            chk_bias;
`endif

  always #5 clk = ~clk;

  imem_loader #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .BASE_ADDR  (BASE),
    .MAX_WORDS  (MAXW),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .chk_expected(chk_expected),
    .checksum    (checksum),
`endif
    .s_ready     (s_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_reset   (cpu_reset),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .word_count  (word_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [AW-1:0] obs_a[$];
  logic [DW-1:0] obs_d[$];
  logic [AW-1:0] exp_a[$];
  logic [DW-1:0] exp_d[$];
  logic [DW-1:0] words[$];
  int            exp_n;
  bit            exp_err;

  int   done_cnt = 0;
  int   done_at  = -1;
  int   fall_at  = -1;
  int   last_wr  = -1;
  logic prev_cr;

  always @(posedge clk) cyc <= cyc + 1;

  // passive monitor: memory writes, done pulses, cpu_reset release
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      obs_a.push_back(mem_addr);
      obs_d.push_back(mem_wdata);
      last_wr = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_at = cyc;
    end
    if (prev_cr === 1'b1 && cpu_reset === 1'b0) fall_at = cyc;
    prev_cr = cpu_reset;
  end

  // expected image: consecutive addresses from BASE, clipped on overflow
  function automatic void model_load(input int n, input bit last);
    exp_a.delete();
    exp_d.delete();
    exp_n = last ? n : ((n >= MAXW) ? MAXW : n);
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_sum = '0;
`endif
    for (int i = 0; i < exp_n; i++) begin
      exp_a.push_back(BASE + AW'(i));
      exp_d.push_back(words[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
      exp_sum = exp_sum + words[i];
`endif
    end
    exp_err = !last && (n >= MAXW);
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_err = exp_err || (last && chk_bias);
`endif
  endfunction

  function automatic int write_diffs();
    int d = 0;
    if (obs_a.size() != exp_a.size()) d++;
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++)
      if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) d++;
    return d;
  endfunction

  task automatic pulse_start();
    @(negedge clk) load_start = 1'b1;
    @(negedge clk) load_start = 1'b0;
  endtask

  // mode 0: continuous, 1: valid every other cycle, 2: random gaps
  task automatic stream(input int n, input bit last, input int mode,
                        input int budget, output int acc);
    int c = 0;
    acc = 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_expected = exp_sum + DW'(chk_bias);
`endif
    while (acc < n && c < budget) begin
      @(negedge clk);
      c++;
      if ((mode == 1 && c % 2 == 0) ||
          (mode == 2 && $urandom_range(0, 2) == 0)) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = words[acc];
        s_last  = last && (acc == n - 1);
        if (s_ready === 1'b1) acc++;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt > 0) ok = 1'b1;
    end
  endtask

  task automatic run_load(input int n, input bit last, input int mode,
                          output int acc, output bit ok);
    obs_a.delete();
    obs_d.delete();
    done_cnt = 0;
    done_at  = -1;
    fall_at  = -1;
    last_wr  = -1;
    model_load(n, last);
    stream(n, last, mode, 8 * n + 20, acc);
    if (last) wait_done(HOLD + 10, ok);
    else ok = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    load_start = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_expected = '0;
    chk_bias = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_ready, mem_we, cpu_reset, busy, done, error} !== 6'b001000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 001000",
               {s_ready, mem_we, cpu_reset, busy, done, error});
    end
    checks++;
    if (mem_addr !== BASE || mem_wdata !== '0 || word_count !== '0) begin
      errors++;
      $display("FAIL reset_regs: got addr %0h data %0h cnt %0d want %0h 0 0",
               mem_addr, mem_wdata, word_count, BASE);
    end
  endtask

  task automatic test_five_word();
    int acc;
    bit ok;
    words = '{16'hC95F, 16'h639F, 16'h1F3D, 16'h1F3D, 16'h03BF};
    pulse_start();
    checks++;
    if ({s_ready, busy, cpu_reset} !== 3'b111) begin
      errors++;
      $display("FAIL five_start: got %b want 111", {s_ready, busy, cpu_reset});
    end
    run_load(5, 1'b1, 0, acc, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL five_done_timeout: got done_cnt %0d want 1", done_cnt);
    end
    checks++;
    if (write_diffs() != 0) begin
      errors++;
      $display("FAIL five_writes: got %0d writes (%0d diffs) want %0d",
               obs_a.size(), write_diffs(), exp_n);
    end
    checks++;
    if (word_count !== CW'(5) || done_cnt != 1) begin
      errors++;
      $display("FAIL five_count: got cnt %0d done %0d want 5 1",
               word_count, done_cnt);
    end
    checks++;
    if (fall_at - last_wr != HOLD || done_at != fall_at) begin
      errors++;
      $display("FAIL five_hold: got fall-wr %0d done@%0d fall@%0d want %0d",
               fall_at - last_wr, done_at, fall_at, HOLD);
    end
    checks++;
    if ({cpu_reset, busy, error, s_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL five_run: got %b want 0000",
               {cpu_reset, busy, error, s_ready});
    end
  endtask

  task automatic test_back_pressure();
    int acc;
    bit ok;
    words.delete();
    for (int i = 0; i < 4; i++) words.push_back(DW'($urandom));
    pulse_start();
    checks++;
    if (cpu_reset !== 1'b1 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_reload: got rst %b rdy %b want 1 1", cpu_reset, s_ready);
    end
    run_load(4, 1'b1, 1, acc, ok);
    checks++;
    if (!ok || write_diffs() != 0 || word_count !== CW'(4)) begin
      errors++;
      $display("FAIL bp_writes: got ok %0d writes %0d cnt %0d want 1 4 4",
               ok, obs_a.size(), word_count);
    end
  endtask

  task automatic test_random_loads();
    int acc;
    int n;
    bit ok;
    for (int k = 0; k < 4; k++) begin
      n = (k == 0) ? MAXW : $urandom_range(1, MAXW);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(DW'($urandom));
      pulse_start();
      run_load(n, 1'b1, 2, acc, ok);
      checks++;
      if (!ok || write_diffs() != 0 || word_count !== CW'(n)) begin
        errors++;
        $display("FAIL rand_load%0d: got ok %0d writes %0d cnt %0d want 1 %0d",
                 k, ok, obs_a.size(), word_count, n);
      end
      checks++;
      if (error !== exp_err || fall_at - last_wr != HOLD || done_cnt != 1) begin
        errors++;
        $display("FAIL rand_state%0d: got err %b hold %0d done %0d want %b %0d 1",
                 k, error, fall_at - last_wr, done_cnt, exp_err, HOLD);
      end
    end
  endtask

  task automatic test_reload_reset();
    int acc;
    bit ok;
    words.delete();
    for (int i = 0; i < 2; i++) words.push_back(DW'($urandom));
    pulse_start();
    run_load(2, 1'b0, 0, acc, ok);
    checks++;
    if (write_diffs() != 0 || word_count !== CW'(2) || busy !== 1'b1) begin
      errors++;
      $display("FAIL reload_writes: got writes %0d cnt %0d busy %b want 2 2 1",
               obs_a.size(), word_count, busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({s_ready, mem_we, cpu_reset, busy, done, error} !== 6'b001000 ||
        mem_addr !== BASE || word_count !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL midload_reset: got %b addr %0h cnt %0d want 001000 %0h 0",
               {s_ready, mem_we, cpu_reset, busy, done, error}, mem_addr,
               word_count, BASE);
    end
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_ready, cpu_reset, busy} !== 3'b010) begin
      errors++;
      $display("FAIL post_reset_idle: got %b want 010", {s_ready, cpu_reset, busy});
    end
  endtask

  task automatic test_overflow();
    int acc;
    bit ok;
    words.delete();
    for (int i = 0; i < MAXW + 1; i++) words.push_back(DW'($urandom));
    pulse_start();
    run_load(MAXW + 1, 1'b0, 2, acc, ok);
    checks++;
    if (acc != MAXW || write_diffs() != 0 || word_count !== CW'(MAXW)) begin
      errors++;
      $display("FAIL ovf_writes: got acc %0d writes %0d cnt %0d want %0d",
               acc, obs_a.size(), word_count, MAXW);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (error !== exp_err || {cpu_reset, busy, s_ready} !== 3'b100) begin
      errors++;
      $display("FAIL ovf_err: got err %b flags %b want %b 100",
               error, {cpu_reset, busy, s_ready}, exp_err);
    end
    pulse_start();
    checks++;
    if (error !== 1'b0 || word_count !== '0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clear: got err %b cnt %0d rdy %b want 0 0 1",
               error, word_count, s_ready);
    end
    words = '{16'hBEEF};
    run_load(1, 1'b1, 0, acc, ok);
    checks++;
    if (!ok || write_diffs() != 0 || cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL ovf_recover: got ok %0d writes %0d rst %b want 1 1 0",
               ok, obs_a.size(), cpu_reset);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int acc;
    bit ok;
    words = '{16'h0001, 16'h0002};
    chk_bias = 1'b0;
    pulse_start();
    run_load(2, 1'b1, 0, acc, ok);
    checks++;
    if (!ok || error !== 1'b0 || checksum !== exp_sum) begin
      errors++;
      $display("FAIL chk_good: got ok %0d err %b sum %0h want 1 0 %0h",
               ok, error, checksum, exp_sum);
    end
    chk_bias = 1'b1;
    pulse_start();
    run_load(2, 1'b1, 0, acc, ok);
    checks++;
    if (ok || error !== exp_err || {cpu_reset, busy} !== 2'b10 ||
        write_diffs() != 0) begin
      errors++;
      $display("FAIL chk_bad: got ok %0d err %b flags %b want 0 %b 10",
               ok, error, {cpu_reset, busy}, exp_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_five_word();
    test_back_pressure();
    test_random_loads();
    test_reload_reset();
    test_overflow();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
